// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic             hi_or_lo;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, rs_val, rt_val, mf_req, hi_or_lo,
    input  rd_data, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_req, hi_or_lo,
    output rd_data, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add MULTU/MADDU unit holding the architectural HI/LO pair.
// Also services MTHI/MTLO writes and MFHI/MFLO reads, stalling ID/EX while busy.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  hilo_muldiv_unit_if.slave   bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       r_state;
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    r_prod;
  logic [CW-1:0]    r_cnt;
  logic             r_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic [W2-1:0]    w_sum;
  logic [W2-1:0]    w_res;
  logic             w_busy;

  // Sum including the current partial term; on the last step this is the full product.
  assign w_sum  = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_res  = r_acc ? ({r_hi, r_lo} + w_sum) : w_sum;
  assign w_busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_acc    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (!bus.op[1]) begin
              r_mcand  <= {{WIDTH{1'b0}}, bus.rs_val};
              r_mplier <= bus.rt_val;
              r_acc    <= bus.op[0];
              r_prod   <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else if (bus.op[0]) begin
              r_lo <= bus.rs_val;
            end else begin
              r_hi <= bus.rs_val;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            {r_hi, r_lo} <= w_res;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data = bus.hi_or_lo ? r_hi : r_lo;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.stall   = w_busy & (bus.start | bus.mf_req);
endmodule
